// File: rtl/asym_sdp_fifo_if.sv
// Producer/consumer bundle for asym_sdp_fifo.
// Signal names match the FIFO's external port list.
interface asym_sdp_fifo_if #(
  parameter int WR_DATA_WIDTH = 9,
  parameter int RD_DATA_WIDTH = 36,
  parameter int CNT_WIDTH     = 13
);
  logic                     WEN_i;
  logic [WR_DATA_WIDTH-1:0] WDATA_i;
  logic                     REN_i;
  logic [RD_DATA_WIDTH-1:0] RDATA_o;
  logic                     RVALID_o;
  logic                     FULL_o;
  logic                     EMPTY_o;
  logic                     ALMOST_FULL_o;
  logic [CNT_WIDTH-1:0]     COUNT_o;
  logic                     OVERFLOW_o;
  logic                     UNDERFLOW_o;

  modport master (
    output WEN_i, WDATA_i, REN_i,
    input  RDATA_o, RVALID_o, FULL_o, EMPTY_o,
    input  ALMOST_FULL_o, COUNT_o,
    input  OVERFLOW_o, UNDERFLOW_o
  );

  modport slave (
    input  WEN_i, WDATA_i, REN_i,
    output RDATA_o, RVALID_o, FULL_o, EMPTY_o,
    output ALMOST_FULL_o, COUNT_o,
    output OVERFLOW_o, UNDERFLOW_o
  );
endinterface

// File: rtl/asym_sdp_fifo.sv
// Single-clock FIFO with asymmetric write/read widths.
// Storage is unit-granular; units pack little-endian into words.
module asym_sdp_fifo #(
  parameter int WR_DATA_WIDTH = 9,
  parameter int RD_DATA_WIDTH = 36,
  parameter int DEPTH_UNITS   = 4096,
  parameter int AFULL_THRESH  = 3584,
  parameter int CNT_WIDTH     = $clog2(DEPTH_UNITS) + 1
) (
  input logic           CLK_i,
  input logic           RST_i,
  asym_sdp_fifo_if.slave bus
);

  localparam int U  = (WR_DATA_WIDTH < RD_DATA_WIDTH) ?
                      WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int WU = WR_DATA_WIDTH / U;
  localparam int RU = RD_DATA_WIDTH / U;
  localparam int AW = $clog2(DEPTH_UNITS);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH_UNITS);
  localparam logic [CNT_WIDTH-1:0] WU_C    = CNT_WIDTH'(WU);
  localparam logic [CNT_WIDTH-1:0] RU_C    = CNT_WIDTH'(RU);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AFULL_THRESH);

  generate
    if (!((WR_DATA_WIDTH == 9) || (WR_DATA_WIDTH == 18) ||
          (WR_DATA_WIDTH == 36)) ||
        !((RD_DATA_WIDTH == 9) || (RD_DATA_WIDTH == 18) ||
          (RD_DATA_WIDTH == 36))) begin : g_bad_width
      $error("asym_sdp_fifo: widths must be 9, 18 or 36");
    end
    if ((DEPTH_UNITS < 4) ||
        ((DEPTH_UNITS & (DEPTH_UNITS - 1)) != 0)) begin : g_bad_depth
      $error("asym_sdp_fifo: DEPTH_UNITS must be a power of two >= 4");
    end
  endgenerate

  logic [U-1:0]             mem_q [DEPTH_UNITS];
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [AW-1:0]            rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic [RD_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RD_DATA_WIDTH-1:0] rd_word;
  logic                     rvalid_q;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     full, empty;
  logic                     wr_acc, rd_acc;
  logic [CNT_WIDTH-1:0]     free_units;

  assign free_units = DEPTH_C - count_q;
  assign full       = free_units < WU_C;
  assign empty      = count_q < RU_C;
  assign wr_acc     = bus.WEN_i & ~full;
  assign rd_acc     = bus.REN_i & ~empty;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RU; i++) begin
      rd_word[i*U +: U] = mem_q[rptr_q + AW'(i)];
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q | (bus.WEN_i & full);
    unf_d   = unf_q | (bus.REN_i & empty);
    count_d = count_q;
    if (wr_acc) begin
      wptr_d  = wptr_q + AW'(WU);
      count_d = count_d + WU_C;
    end
    if (rd_acc) begin
      rptr_d  = rptr_q + AW'(RU);
      rdata_d = rd_word;
      count_d = count_d - RU_C;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Contents survive reset; only the pointers define what is stored.
  always_ff @(posedge CLK_i) begin
    if (!RST_i && wr_acc) begin
      for (int i = 0; i < WU; i++) begin
        mem_q[wptr_q + AW'(i)] <= bus.WDATA_i[i*U +: U];
      end
    end
  end

  assign bus.RDATA_o       = rdata_q;
  assign bus.RVALID_o      = rvalid_q;
  assign bus.FULL_o        = full;
  assign bus.EMPTY_o       = empty;
  assign bus.ALMOST_FULL_o = count_q >= AF_C;
  assign bus.COUNT_o       = count_q;
  assign bus.OVERFLOW_o    = ovf_q;
  assign bus.UNDERFLOW_o   = unf_q;

endmodule
